// File: rtl/wb_regfile.sv
// Writeback-stage register file: WB mux, 32 x XLEN integer registers (x0 reads zero),
// two combinational decode read ports and a wrapping retired-write counter.
// Optional macro WB_BYPASS_EN: same-cycle write-through from writeback to the read ports.
module wb_regfile #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       mem_wb_rd,
    input  logic             mem_wb_regwrite,
    input  logic             mem_wb_mem_to_reg,
    input  logic [XLEN-1:0]  mem_wb_alu_result,
    input  logic [XLEN-1:0]  mem_wb_mem_rdata,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    output logic [XLEN-1:0]  id_rs1_data,
    output logic [XLEN-1:0]  id_rs2_data,
    output logic [XLEN-1:0]  wb_data,
    output logic [CNT_W-1:0] wb_retire_cnt
);

    logic [XLEN-1:0]  regs [32];
    logic [CNT_W-1:0] retire_cnt;
    logic             commit;

    // Modulo-2^CNT_W increment; the counter wraps silently.
    function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] c);
        return c + CNT_W'(1);
    endfunction

    assign wb_data = mem_wb_mem_to_reg ? mem_wb_mem_rdata : mem_wb_alu_result;
    assign commit  = rst && mem_wb_regwrite && (mem_wb_rd != 5'd0);

    // Entry 0 is cleared on reset and never written, so it always holds zero.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= '0;
            end
            retire_cnt <= '0;
        end else if (commit) begin
            regs[mem_wb_rd] <= wb_data;
            retire_cnt      <= cnt_inc(retire_cnt);
        end
    end

    always_comb begin
        id_rs1_data = regs[id_rs1];
`ifdef WB_BYPASS_EN
        if (commit && (id_rs1 == mem_wb_rd)) id_rs1_data = wb_data;
`endif
        if (!rst || (id_rs1 == 5'd0)) id_rs1_data = '0;
    end

    always_comb begin
        id_rs2_data = regs[id_rs2];
`ifdef WB_BYPASS_EN
        if (commit && (id_rs2 == mem_wb_rd)) id_rs2_data = wb_data;
`endif
        if (!rst || (id_rs2 == 5'd0)) id_rs2_data = '0;
    end

    assign wb_retire_cnt = retire_cnt;

endmodule
